// File: rtl/maindec_fsm.sv
// maindec_fsm: multicycle RV32I control FSM sequencing fetch/decode/execute/memory/write-back.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   opcode     instr[6:0] from the instruction register (sampled in DECODE only)
//   zero       ALU zero flag, qualifies the beq PC write
//   mem_ready  memory access completes this cycle (ignored when MEM_HANDSHAKE=0)
//   PCWrite    PC enable = PCUpdate | (Branch & zero)
//   AdrSrc     memory address select: 0 PC, 1 ALUOut
//   MemRead    memory read strobe
//   MemWrite   memory write strobe
//   IRWrite    latch instruction and OldPC
//   RegWrite   register file write enable
//   ResultSrc  00 ALUOut, 01 ReadData, 10 ALUResult
//   ALUSrcA    00 PC, 01 OldPC, 10 rs1, 11 zero
//   ALUSrcB    00 rs2, 01 ImmExt, 10 const 4
//   ALUOp      00 add, 01 sub/branch, 10 funct-decoded
//   ImmSrc     000 I, 001 S, 010 B, 011 J, 100 U (from opcode)
//   illegal    sticky trap flag, cleared only by reset
//   state      current state encoding
module maindec_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit EXT_OPS       = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       illegal,
  output logic [3:0] state
);
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_LUI      = 4'd12;
  localparam logic [3:0] S_TRAP     = 4'd13;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       r_store;
  logic       w_rdy;
  logic       w_pcupdate;
  logic       w_branch;
  logic       w_irwrite;
  logic       w_memread;
  logic       w_memwrite;
  logic       w_regwrite;

  assign w_rdy = !MEM_HANDSHAKE || mem_ready;

  // r_store remembers lw vs sw from DECODE so MEMADR does not look at opcode again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_store <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_store <= (opcode == OP_SW);
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = w_rdy ? S_DECODE : S_FETCH;
      S_DECODE:
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          OP_JALR:      w_next = EXT_OPS ? S_JALR : S_TRAP;
          OP_LUI:       w_next = EXT_OPS ? S_LUI : S_TRAP;
          default:      w_next = S_TRAP;
        endcase
      S_MEMADR:   w_next = r_store ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = w_rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = w_rdy ? S_FETCH : S_MEMWRITE;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_JALR:     w_next = S_JAL;
      S_LUI:      w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  // IRWrite/PCUpdate fire only on the completing fetch cycle so PC advances once per fetch.
  always_comb begin
    w_pcupdate = 1'b0;
    w_branch   = 1'b0;
    w_irwrite  = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_memread  = 1'b1;
        w_irwrite  = w_rdy;
        w_pcupdate = w_rdy;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        w_memread = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        w_regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: w_regwrite = 1'b1;
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        ALUOp    = 2'b01;
        w_branch = 1'b1;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        w_pcupdate = 1'b1;
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      default: ;
    endcase
  end

  always_comb begin
    ImmSrc = 3'b000;
    case (opcode)
      OP_SW:   ImmSrc = 3'b001;
      OP_BEQ:  ImmSrc = 3'b010;
      OP_JAL:  ImmSrc = 3'b011;
      OP_LUI:  ImmSrc = 3'b100;
      default: ImmSrc = 3'b000;
    endcase
  end

  // Write strobes are gated by rst_n so they drop the instant reset asserts.
  assign PCWrite  = rst_n && (w_pcupdate || (w_branch && zero));
  assign IRWrite  = rst_n && w_irwrite;
  assign MemRead  = rst_n && w_memread;
  assign MemWrite = rst_n && w_memwrite;
  assign RegWrite = rst_n && w_regwrite;
  assign illegal  = (r_state == S_TRAP);
  assign state    = r_state;
endmodule

// File: tb/tb_maindec_fsm.sv
// tb_maindec_fsm: directed bench for maindec_fsm with EXT_OPS=1 and EXT_OPS=0 instances.
module tb_maindec_fsm;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'b0000011;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic [3:0] state;
  logic       n_PCWrite, n_AdrSrc, n_MemRead, n_MemWrite, n_IRWrite, n_RegWrite, n_illegal;
  logic [1:0] n_ResultSrc, n_ALUSrcA, n_ALUSrcB, n_ALUOp;
  logic [2:0] n_ImmSrc;
  logic [3:0] n_state;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  maindec_fsm #(.MEM_HANDSHAKE(1'b1), .EXT_OPS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .illegal(illegal), .state(state)
  );

  maindec_fsm #(.MEM_HANDSHAKE(1'b1), .EXT_OPS(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(n_PCWrite), .AdrSrc(n_AdrSrc), .MemRead(n_MemRead), .MemWrite(n_MemWrite),
    .IRWrite(n_IRWrite), .RegWrite(n_RegWrite), .ResultSrc(n_ResultSrc), .ALUSrcA(n_ALUSrcA),
    .ALUSrcB(n_ALUSrcB), .ALUOp(n_ALUOp), .ImmSrc(n_ImmSrc), .illegal(n_illegal), .state(n_state)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int st[6] = '{0, 1, 2, 3, 4, 0};
    rst_n = 1'b0; opcode = 7'b0000011; mem_ready = 1'b1;
    #3;
    n_vec++;
    if (state !== 4'd0 || illegal !== 1'b0) begin n_err++; $display("FAIL reset_state: state %0d illegal %0b want 0 0", state, illegal); end
    n_vec++;
    if ({IRWrite, PCWrite, RegWrite, MemWrite, MemRead} !== 5'b0) begin n_err++; $display("FAIL reset_strobes: got %b want 00000", {IRWrite, PCWrite, RegWrite, MemWrite, MemRead}); end
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_vec++;
      if (state !== 4'(st[i])) begin n_err++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, st[i]); end
      n_vec++;
      if (RegWrite !== (st[i] == 4)) begin n_err++; $display("FAIL lw_regwrite[%0d]: got %b want %b", i, RegWrite, st[i] == 4); end
      if (st[i] == 4) begin
        n_vec++;
        if (ResultSrc !== 2'b01) begin n_err++; $display("FAIL lw_resultsrc: got %b want 01", ResultSrc); end
      end
      n_vec++;
      if (ImmSrc !== 3'b000) begin n_err++; $display("FAIL lw_immsrc: got %b want 000", ImmSrc); end
      if (i < 5) cyc();
    end
  endtask

  task automatic test_sw_handshake();
    int st[10]  = '{0, 0, 0, 0, 1, 2, 5, 5, 5, 0};
    bit rdy[10] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1};
    bit pcw[10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    bit mw[10]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
    int n_pc = 0;
    int n_mw = 0;
    opcode = 7'b0100011;
    for (int i = 0; i < 10; i++) begin
      mem_ready = rdy[i];
      #1;
      n_vec++;
      if (state !== 4'(st[i])) begin n_err++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, st[i]); end
      n_vec++;
      if (PCWrite !== pcw[i] || IRWrite !== pcw[i]) begin n_err++; $display("FAIL sw_pcwrite[%0d]: pc %b ir %b want %b", i, PCWrite, IRWrite, pcw[i]); end
      n_vec++;
      if (MemWrite !== mw[i]) begin n_err++; $display("FAIL sw_memwrite[%0d]: got %b want %b", i, MemWrite, mw[i]); end
      if (st[i] == 0) begin
        n_vec++;
        if (MemRead !== 1'b1 || AdrSrc !== 1'b0) begin n_err++; $display("FAIL sw_fetch_mem[%0d]: MemRead %b AdrSrc %b want 1 0", i, MemRead, AdrSrc); end
      end
      if (st[i] == 5) begin
        n_vec++;
        if (AdrSrc !== 1'b1) begin n_err++; $display("FAIL sw_adrsrc[%0d]: got %b want 1", i, AdrSrc); end
      end
      if (i < 4) n_pc += int'(PCWrite);
      n_mw += int'(MemWrite);
      if (i < 9) cyc();
    end
    n_vec++;
    if (n_pc != 1 || n_mw != 3) begin n_err++; $display("FAIL sw_pulse_counts: pc %0d mw %0d want 1 3", n_pc, n_mw); end
    n_vec++;
    if (ImmSrc !== 3'b001) begin n_err++; $display("FAIL sw_immsrc: got %b want 001", ImmSrc); end
  endtask

  task automatic test_beq();
    int st[4] = '{0, 1, 9, 0};
    opcode = 7'b1100011; mem_ready = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      for (int i = 0; i < 4; i++) begin
        #1;
        n_vec++;
        if (state !== 4'(st[i])) begin n_err++; $display("FAIL beq%0d_state[%0d]: got %0d want %0d", z, i, state, st[i]); end
        n_vec++;
        if (PCWrite !== (i != 1 && (i != 2 || z == 1))) begin n_err++; $display("FAIL beq%0d_pcwrite[%0d]: got %b want %b", z, i, PCWrite, (i != 1 && (i != 2 || z == 1))); end
        if (i == 2) begin
          n_vec++;
          if (ALUOp !== 2'b01 || ALUSrcA !== 2'b10 || ALUSrcB !== 2'b00) begin n_err++; $display("FAIL beq_alu: op %b a %b b %b want 01 10 00", ALUOp, ALUSrcA, ALUSrcB); end
          n_vec++;
          if (ImmSrc !== 3'b010) begin n_err++; $display("FAIL beq_immsrc: got %b want 010", ImmSrc); end
        end
        if (i < 3) cyc();
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jalr_trap();
    int st[6]   = '{0, 1, 11, 10, 8, 0};
    int nst[6]  = '{0, 1, 13, 13, 13, 13};
    bit pcw[6]  = '{1, 0, 0, 1, 0, 1};
    int rpat[4] = '{0, 1, 6, 8};
    opcode = 7'b1100111; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_vec++;
      if (state !== 4'(st[i])) begin n_err++; $display("FAIL jalr_state[%0d]: got %0d want %0d", i, state, st[i]); end
      n_vec++;
      if (PCWrite !== pcw[i]) begin n_err++; $display("FAIL jalr_pcwrite[%0d]: got %b want %b", i, PCWrite, pcw[i]); end
      n_vec++;
      if (n_state !== 4'(nst[i])) begin n_err++; $display("FAIL noext_state[%0d]: got %0d want %0d", i, n_state, nst[i]); end
      if (i < 5) cyc();
    end
    opcode = 7'b0110011;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_vec++;
      if (state !== 4'(rpat[(i + 1) % 4])) begin n_err++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state, rpat[(i + 1) % 4]); end
      n_vec++;
      if (n_state !== 4'd13 || n_illegal !== 1'b1) begin n_err++; $display("FAIL trap_hold[%0d]: state %0d illegal %b want 13 1", i, n_state, n_illegal); end
      n_vec++;
      if ({n_PCWrite, n_IRWrite, n_MemRead, n_MemWrite, n_RegWrite} !== 5'b0) begin n_err++; $display("FAIL trap_strobes[%0d]: got %b want 00000", i, {n_PCWrite, n_IRWrite, n_MemRead, n_MemWrite, n_RegWrite}); end
    end
  endtask

  task automatic test_lui();
    int st[5] = '{0, 1, 12, 8, 0};
    opcode = 7'b0110111; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++;
      if (state !== 4'(st[i])) begin n_err++; $display("FAIL lui_state[%0d]: got %0d want %0d", i, state, st[i]); end
      n_vec++;
      if (RegWrite !== (i == 3)) begin n_err++; $display("FAIL lui_regwrite[%0d]: got %b want %b", i, RegWrite, i == 3); end
      if (i == 2) begin
        n_vec++;
        if (ALUSrcA !== 2'b11 || ALUSrcB !== 2'b01 || ImmSrc !== 3'b100) begin n_err++; $display("FAIL lui_ctrl: a %b b %b imm %b want 11 01 100", ALUSrcA, ALUSrcB, ImmSrc); end
      end
      if (i < 4) cyc();
    end
  endtask

  task automatic test_opcode_sample();
    int st[5] = '{0, 1, 2, 3, 4};
    opcode = 7'b0000000; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      opcode = (i == 1) ? 7'b0000011 : (i == 0 ? 7'b0000000 : 7'b0100011);
      #1;
      n_vec++;
      if (state !== 4'(st[i])) begin n_err++; $display("FAIL sample_state[%0d]: got %0d want %0d", i, state, st[i]); end
      if (i == 3) begin
        n_vec++;
        if (MemRead !== 1'b1 || MemWrite !== 1'b0) begin n_err++; $display("FAIL sample_strobes: rd %b wr %b want 1 0", MemRead, MemWrite); end
      end
      cyc();
    end
    n_vec++;
    if (state !== 4'd0) begin n_err++; $display("FAIL sample_return: got %0d want 0", state); end
  endtask

  task automatic test_mid_reset();
    int st[3] = '{0, 1, 2};
    opcode = 7'b0100011; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (state !== 4'(st[i])) begin n_err++; $display("FAIL rst_pre_state[%0d]: got %0d want %0d", i, state, st[i]); end
      cyc();
    end
    mem_ready = 1'b0;
    #1;
    n_vec++;
    if (state !== 4'd5 || MemWrite !== 1'b1) begin n_err++; $display("FAIL rst_memwrite: state %0d wr %b want 5 1", state, MemWrite); end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (MemWrite !== 1'b0 || state !== 4'd0 || illegal !== 1'b0) begin n_err++; $display("FAIL rst_async: wr %b state %0d illegal %b want 0 0 0", MemWrite, state, illegal); end
    n_vec++;
    if (n_illegal !== 1'b0 || n_state !== 4'd0) begin n_err++; $display("FAIL rst_trap_clear: illegal %b state %0d want 0 0", n_illegal, n_state); end
    cyc();
    rst_n = 1'b1; mem_ready = 1'b1;
    #1;
    n_vec++;
    if (state !== 4'd0 || MemRead !== 1'b1) begin n_err++; $display("FAIL rst_release: state %0d rd %b want 0 1", state, MemRead); end
    cyc();
    n_vec++;
    if (state !== 4'd1) begin n_err++; $display("FAIL rst_first_fetch: got %0d want 1", state); end
  endtask

  initial begin
    test_reset();
    test_sw_handshake();
    test_beq();
    test_jalr_trap();
    test_lui();
    test_opcode_sample();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
